vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Shares VRAM write port B between several pixel-write engines: the clear engine, a future line rasterizer fed from the edge buffer, and a single-pixel plot command.
- Round-robin arbitration with bounded bursts, so one bulk clear cannot starve the other engines.
- Registered write outputs with an address range check.
- Sits between the command engines and the port-B inputs of the dual-clock VRAM, all in the CLK domain.

Parameters:
- NREQ, 3, number of requesters (index 0 = clear, 1 = line, 2 = plot).
- ADDR_W, 18, VRAM byte-address width.
- TOTAL_BYTES, 98304, VRAM size; addresses >= this are out of range.
- MAX_BURST, 64, maximum beats accepted per grant before rotating.

Ports:
- CLK  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- pause  in  1  when high, no beat is accepted (ready forced low); the grant is held.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NREQ*8  per-requester pixel byte; requester i occupies bits [i*8 +: 8].
- req_ready  out  NREQ  beat accept; one-hot or zero.
- vram_addr_b  out  ADDR_W  registered VRAM address.
- vram_data_b  out  8  registered VRAM data.
- vram_we_b  out  1  registered write enable.
- owner  out  $clog2(NREQ)  current or last grant index.
- BUSY  out  1  high while in GRANT or while a write is in flight.
- err_range  out  1  one-cycle pulse for a dropped out-of-range beat.

Behaviour:
- Reset (async, rst=1): state=IDLE, owner=0, rr pointer=0, burst count=0, req_ready=0, vram_we_b=0, vram_addr_b=0, vram_data_b=0, BUSY=0, err_range=0.
- State IDLE:
  - req_ready=0.
  - If any req_valid, the winner is the first set bit searching from (last_owner+1) mod NREQ, wrapping.
  - Next cycle: state=GRANT, owner=winner, burst count=0.
  - If no valid, stay in IDLE.
- State GRANT:
  - req_ready[owner] = !pause; all other ready bits are 0.
  - Beat = req_valid[owner] & req_ready[owner].
  - On a beat, burst count increments.
  - Return to IDLE (last_owner=owner) when either:
    - a beat occurs with burst count == MAX_BURST-1, or
    - req_valid[owner]==0 and pause==0.
  - A paused grant does not release on a valid drop.
- Write path, one-cycle latency:
  - A beat at cycle t with addr < TOTAL_BYTES gives vram_we_b=1 at t+1, with addr and data from cycle t.
  - A beat at cycle t with addr >= TOTAL_BYTES gives vram_we_b=0 and err_range=1 at t+1; the beat is still consumed.
  - With no beat, vram_we_b=0 at t+1 and the address/data registers hold their values.
- Arbitration overhead: one idle cycle per grant.
  - Full-rate single-requester throughput = MAX_BURST/(MAX_BURST+1).
- Simultaneous events:
  - All requesters valid: service order rotates 0,1,2,0,...
  - Owner drops valid on the same cycle another requester raises it: return to IDLE, then the newcomer wins if it is next in the rotation.
  - pause rising mid-burst: ready falls in the same cycle (combinational), burst count is frozen, resume continues the same burst.
- Requesters must hold addr/data stable while valid and not ready.
- BUSY = (state==GRANT) | vram_we_b.
- Reset mid-burst: the in-flight write is lost (we forced 0); requesters re-request after reset.
- Requester indices >= NREQ never occur.

Decomposition:
- Shared constants header: VRAM_ADDR_W=18, VRAM_TOTAL_BYTES=98304, requester index defines REQ_CLEAR=0, REQ_LINE=1, REQ_PLOT=2. cmd_clear and the top level include the same header.
- Sub-module rr_pick: purely combinational.
  - Inputs: valid vector, last index.
  - Outputs: winner index and any flag.
  - Reused later for edge-buffer read-port sharing.

Test Plan:
- Reset: pulse rst asynchronously mid-cycle -> all outputs 0 immediately; owner=0.
- Single requester: REQ_PLOT valid for 1 beat with addr=0x00100, data=0x3C -> state GRANT at t+1, ready at t+1, vram_we_b=1 at t+2 with addr=0x00100, data=0x3C.
- Burst limit: REQ_CLEAR valid continuously with MAX_BURST=64 -> exactly 64 consecutive writes, 1 idle cycle, then 64 more; owner stays 0.
- Fairness: all three requesters valid continuously -> grants rotate 0,1,2,0; each grant yields 64 beats; no requester waits more than 2*(MAX_BURST+1)+1 cycles.
- Range: beat with addr=98304 -> vram_we_b=0, err_range=1 for exactly one cycle, ready consumed the beat; a following beat at addr=98303 writes normally.
- Pause: pause=1 for 5 cycles mid-burst at beat 10 -> no ready and no writes during the pause; after release, beats 10..63 complete in the same grant without re-arbitration.

Source files
------------

// File: rtl/vram_port_arbiter_pkg.sv
// vram_port_arbiter_pkg
//   Shared constants for the VRAM port-B writers: VRAM geometry, requester
//   indices, arbiter sizing and the arbiter FSM state type.
//   No ports (package).
package vram_port_arbiter_pkg;

    localparam int unsigned VRAM_ADDR_W      = 18;
    localparam int unsigned VRAM_TOTAL_BYTES = 98304;

    // Requester slots on the port-B arbiter.
    localparam int unsigned REQ_CLEAR = 0;
    localparam int unsigned REQ_LINE  = 1;
    localparam int unsigned REQ_PLOT  = 2;

    localparam int unsigned ARB_NREQ      = 3;
    localparam int unsigned ARB_MAX_BURST = 64;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vram_port_arbiter_rr_pick.sv
// vram_port_arbiter_rr_pick
//   Combinational round-robin picker: returns the first set bit of 'valid'
//   searching upward from (last + 1) mod N, wrapping around.
//   Ports:
//     valid   in  N   request vector
//     last    in  IW  index granted most recently
//     winner  out IW  selected index (0 when nothing is valid)
//     any     out 1   at least one request is valid
module vram_port_arbiter_rr_pick
    import vram_port_arbiter_pkg::*;
#(
    parameter int unsigned N  = ARB_NREQ,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          any
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        // Walk from the farthest candidate to the nearest so the nearest set
        // bit after 'last' is the one left standing.
        for (int unsigned k = N; k >= 1; k--) begin
            idx = (32'(last) + k) % N;
            if (valid[idx]) begin
                winner = IW'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
//   Round-robin arbiter sharing VRAM write port B between the clear engine,
//   the line rasterizer and the single-pixel plot command. Bursts are capped
//   at MAX_BURST beats per grant; write outputs are registered and beats
//   addressed past the end of VRAM are dropped with an err_range pulse.
//   Ports:
//     CLK          in   system clock
//     rst          in   asynchronous active-high reset
//     pause        in   hold off all beats, keep the grant
//     req_valid    in   NREQ per-requester write request
//     req_addr     in   NREQ*ADDR_W, requester i at [i*ADDR_W +: ADDR_W]
//     req_data     in   NREQ*8, requester i at [i*8 +: 8]
//     req_ready    out  NREQ beat accept (one-hot or zero)
//     vram_addr_b  out  registered VRAM address
//     vram_data_b  out  registered VRAM data
//     vram_we_b    out  registered write enable
//     owner        out  current or last grant index
//     BUSY         out  granting or write in flight
//     err_range    out  one-cycle pulse per dropped out-of-range beat
module vram_port_arbiter
    import vram_port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ        = ARB_NREQ,
    parameter int unsigned ADDR_W      = VRAM_ADDR_W,
    parameter int unsigned TOTAL_BYTES = VRAM_TOTAL_BYTES,
    parameter int unsigned MAX_BURST   = ARB_MAX_BURST,
    parameter int unsigned OW          = idx_w(NREQ)
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   pause,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*8-1:0]      req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]      vram_addr_b,
    output logic [7:0]             vram_data_b,
    output logic                   vram_we_b,
    output logic [OW-1:0]          owner,
    output logic                   BUSY,
    output logic                   err_range
);

    localparam int unsigned CW = idx_w(MAX_BURST);

    arb_state_e        state_q;
    logic [OW-1:0]     rr_q;
    logic [CW-1:0]     burst_q;

    logic [OW-1:0]     pick_idx;
    logic              pick_any;
    logic              granted;
    logic              owner_valid;
    logic              beat;
    logic              last_beat;
    logic              release_grant;
    logic              in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_data;

    vram_port_arbiter_rr_pick #(
        .N  (NREQ),
        .IW (OW)
    ) u_rr_pick (
        .valid  (req_valid),
        .last   (rr_q),
        .winner (pick_idx),
        .any    (pick_any)
    );

    assign granted     = (state_q == StGrant);
    assign owner_valid = req_valid[owner];
    assign sel_addr    = req_addr[owner*ADDR_W +: ADDR_W];
    assign sel_data    = req_data[owner*8 +: 8];
    assign in_range    = 32'(sel_addr) < TOTAL_BYTES;

    // Ready is combinational so pause blocks the beat in the same cycle.
    always_comb begin
        req_ready = '0;
        if (granted && !pause) begin
            req_ready[owner] = 1'b1;
        end
    end

    assign beat      = granted && !pause && owner_valid;
    assign last_beat = beat && (burst_q == CW'(MAX_BURST - 1));
    // A paused owner keeps its grant even if it drops valid.
    assign release_grant = last_beat || (granted && !owner_valid && !pause);

    assign BUSY = granted | vram_we_b;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner       <= '0;
            rr_q        <= '0;
            burst_q     <= '0;
            vram_we_b   <= 1'b0;
            err_range   <= 1'b0;
            vram_addr_b <= '0;
            vram_data_b <= '0;
        end else begin
            vram_we_b <= beat && in_range;
            err_range <= beat && !in_range;
            if (beat && in_range) begin
                vram_addr_b <= sel_addr;
                vram_data_b <= sel_data;
            end

            case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        state_q <= StGrant;
                        owner   <= pick_idx;
                        burst_q <= '0;
                    end
                end
                StGrant: begin
                    if (release_grant) begin
                        state_q <= StIdle;
                        rr_q    <= owner;
                    end else if (beat) begin
                        burst_q <= burst_q + CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
module tb_vram_port_arbiter;
    import vram_port_arbiter_pkg::*;

    localparam int          NR = 3;
    localparam int          AW = 18;
    localparam int          MB = 64;
    localparam logic [31:0] TB = 32'd98304;

    logic           CLK;
    logic           rst;
    logic           pause;
    logic [2:0]     req_valid;
    logic [53:0]    req_addr;
    logic [23:0]    req_data;
    logic [2:0]     req_ready;
    logic [17:0]    vram_addr_b;
    logic [7:0]     vram_data_b;
    logic           vram_we_b;
    logic [1:0]     owner;
    logic           BUSY;
    logic           err_range;

    vram_port_arbiter #(
        .NREQ        (3),
        .ADDR_W      (18),
        .TOTAL_BYTES (98304),
        .MAX_BURST   (64)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .pause       (pause),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .vram_addr_b (vram_addr_b),
        .vram_data_b (vram_data_b),
        .vram_we_b   (vram_we_b),
        .owner       (owner),
        .BUSY        (BUSY),
        .err_range   (err_range)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        err;
        logic [17:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;

    // Requester side: beats still to send, current address/data.
    int          r_left[3];
    logic [17:0] r_addr[3];
    logic [7:0]  r_data[3];
    int          beats_by[3];

    // Reference model of the arbiter.
    logic        m_grant;
    int          m_owner;
    int          m_rr;
    int          m_cnt;
    logic        m_we;

    int          runs[$];
    int          run_len;
    int          grants[$];
    logic [2:0]  prev_rdy;
    int          waitc[3];
    int          maxw;
    int          err_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = (r_left[i] != 0);
            req_addr[i*AW +: AW]   = r_addr[i];
            req_data[i*8 +: 8]     = r_data[i];
        end
    endtask

    task automatic model_reset();
        m_grant = 1'b0;
        m_owner = 0;
        m_rr    = 0;
        m_cnt   = 0;
        m_we    = 1'b0;
        sbq.delete();
    endtask

    // One clock: check combinational outputs, predict, clock, check the
    // registered outputs against the scoreboard, then let requesters react.
    task automatic step();
        logic [2:0] m_rdy;
        logic       m_beat;
        logic       m_inr;
        logic       found;
        int         b_own;
        exp_t       e;
        exp_t       got;
        #1;
        m_rdy = '0;
        if (m_grant && !pause) m_rdy[m_owner] = 1'b1;
        m_beat = m_grant && !pause && req_valid[m_owner];
        chk("ready", 32'(req_ready), 32'(m_rdy));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("busy", 32'(BUSY), 32'(m_grant | m_we));
        if (req_ready != 3'b000 && prev_rdy == 3'b000) grants.push_back(int'(owner));
        prev_rdy = req_ready;
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && !req_ready[i]) waitc[i]++;
            else waitc[i] = 0;
            if (waitc[i] > maxw) maxw = waitc[i];
        end
        b_own = m_owner;
        m_inr = (32'(r_addr[b_own]) < TB);
        if (m_beat) begin
            e.err  = !m_inr;
            e.addr = r_addr[b_own];
            e.data = r_data[b_own];
            sbq.push_back(e);
        end

        @(posedge CLK);
        if (!m_grant) begin
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
                if (!found && req_valid[(m_rr + k) % NR]) begin
                    found   = 1'b1;
                    m_owner = (m_rr + k) % NR;
                end
            end
            if (found) begin
                m_grant = 1'b1;
                m_cnt   = 0;
            end
        end else if ((m_beat && m_cnt == MB - 1) || (!req_valid[m_owner] && !pause)) begin
            m_grant = 1'b0;
            m_rr    = m_owner;
        end else if (m_beat) begin
            m_cnt++;
        end
        m_we = m_beat && m_inr;

        #1;
        if (vram_we_b || err_range) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected", 32'({vram_we_b, err_range}), 32'd0);
            end else begin
                got = sbq.pop_front();
                chk("sb_err", 32'(err_range), 32'(got.err));
                chk("sb_we", 32'(vram_we_b), 32'(!got.err));
                if (!got.err) begin
                    chk("sb_addr", 32'(vram_addr_b), 32'(got.addr));
                    chk("sb_data", 32'(vram_data_b), 32'(got.data));
                end
            end
        end
        chk("sb_pending", 32'(sbq.size()), 32'd0);
        if (err_range) err_cnt++;
        if (vram_we_b) begin
            run_len++;
        end else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end

        if (m_beat) begin
            r_addr[b_own] = r_addr[b_own] + 18'd1;
            r_data[b_own] = r_data[b_own] + 8'd1;
            if (r_left[b_own] > 0) r_left[b_own]--;
            beats_by[b_own]++;
        end
        drive();
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int n;
        n = 0;
        while ((r_left[0] != 0 || r_left[1] != 0 || r_left[2] != 0) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 32'(r_left[0] + r_left[1] + r_left[2]), 32'd0);
        repeat (3) step();
    endtask

    initial begin
        int n;
        logic paused;
        int exp_order[6];
        exp_order = '{1, 2, 0, 1, 2, 0};

        rst   = 1'b1;
        pause = 1'b0;
        for (int i = 0; i < NR; i++) begin
            r_left[i]   = 0;
            r_addr[i]   = '0;
            r_data[i]   = '0;
            beats_by[i] = 0;
            waitc[i]    = 0;
        end
        drive();
        model_reset();
        run_len  = 0;
        prev_rdy = '0;
        maxw     = 0;
        err_cnt  = 0;
        #1;
        chk("rst_we", 32'(vram_we_b), 32'd0);
        chk("rst_err", 32'(err_range), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_addr", 32'(vram_addr_b), 32'd0);
        chk("rst_data", 32'(vram_data_b), 32'd0);
        @(posedge CLK);
        #1 rst = 1'b0;

        // Single plot beat.
        runs.delete();
        grants.delete();
        r_addr[REQ_PLOT] = 18'h00100;
        r_data[REQ_PLOT] = 8'h3C;
        r_left[REQ_PLOT] = 1;
        drive();
        run_until_done(20, "plot");
        chk("plot_runs", 32'(runs.size()), 32'd1);
        if (runs.size() > 0) chk("plot_run0", 32'(runs[0]), 32'd1);
        chk("plot_grants", 32'(grants.size()), 32'd1);
        if (grants.size() > 0) chk("plot_owner", 32'(grants[0]), 32'd2);

        // Clear alone: two capped bursts.
        runs.delete();
        grants.delete();
        r_addr[REQ_CLEAR] = '0;
        r_data[REQ_CLEAR] = '0;
        r_left[REQ_CLEAR] = 128;
        drive();
        run_until_done(400, "burst");
        chk("burst_runs", 32'(runs.size()), 32'd2);
        foreach (runs[i]) chk("burst_len", 32'(runs[i]), 32'd64);
        chk("burst_grants", 32'(grants.size()), 32'd2);
        foreach (grants[i]) chk("burst_owner", 32'(grants[i]), 32'd0);

        // Range check: first address past the end, then the last valid one.
        runs.delete();
        err_cnt = 0;
        r_addr[REQ_PLOT] = 18'd98304;
        r_data[REQ_PLOT] = 8'h55;
        r_left[REQ_PLOT] = 1;
        drive();
        run_until_done(20, "range_oob");
        chk("range_err_cnt", 32'(err_cnt), 32'd1);
        chk("range_no_write", 32'(runs.size()), 32'd0);
        r_addr[REQ_PLOT] = 18'd98303;
        r_data[REQ_PLOT] = 8'h66;
        r_left[REQ_PLOT] = 1;
        drive();
        run_until_done(20, "range_ok");
        chk("range_err_cnt2", 32'(err_cnt), 32'd1);
        chk("range_write", 32'(runs.size()), 32'd1);

        // Pause for 5 cycles after beat 10 of a clear burst.
        runs.delete();
        beats_by[REQ_CLEAR] = 0;
        r_addr[REQ_CLEAR]   = 18'h01000;
        r_left[REQ_CLEAR]   = 64;
        drive();
        paused = 1'b0;
        n = 0;
        while (r_left[REQ_CLEAR] != 0 && n < 300) begin
            step();
            n++;
            if (beats_by[REQ_CLEAR] == 10 && !paused) begin
                paused = 1'b1;
                pause  = 1'b1;
                repeat (5) begin
                    step();
                    chk("pause_ready", 32'(req_ready), 32'd0);
                    chk("pause_busy", 32'(BUSY), 32'd1);
                end
                pause = 1'b0;
            end
        end
        chk("pause_done", 32'(r_left[REQ_CLEAR]), 32'd0);
        repeat (3) step();
        chk("pause_runs", 32'(runs.size()), 32'd2);
        if (runs.size() == 2) begin
            chk("pause_run0", 32'(runs[0]), 32'd10);
            chk("pause_run1", 32'(runs[1]), 32'd54);
        end

        // All three requesters valid: rotation, burst cap, bounded wait.
        runs.delete();
        grants.delete();
        maxw = 0;
        r_addr[0] = 18'h00000;
        r_addr[1] = 18'h08000;
        r_addr[2] = 18'h10000;
        for (int i = 0; i < NR; i++) begin
            r_left[i] = 128;
            waitc[i]  = 0;
        end
        drive();
        run_until_done(1000, "fair");
        chk("fair_grants", 32'(grants.size()), 32'd6);
        if (grants.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("fair_order", 32'(grants[i]), 32'(exp_order[i]));
        end
        chk("fair_runs", 32'(runs.size()), 32'd6);
        foreach (runs[i]) chk("fair_len", 32'(runs[i]), 32'd64);
        chk("fair_max_wait", 32'(maxw <= 2 * (MB + 1) + 1), 32'd1);

        // Asynchronous reset in the middle of a plot burst.
        beats_by[REQ_PLOT] = 0;
        r_addr[REQ_PLOT]   = 18'h00200;
        r_left[REQ_PLOT]   = 50;
        drive();
        n = 0;
        while (beats_by[REQ_PLOT] < 5 && n < 50) begin
            step();
            n++;
        end
        chk("rstmid_beats", 32'(beats_by[REQ_PLOT]), 32'd5);
        chk("rstmid_we_pre", 32'(vram_we_b), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("rstmid_we", 32'(vram_we_b), 32'd0);
        chk("rstmid_err", 32'(err_range), 32'd0);
        chk("rstmid_ready", 32'(req_ready), 32'd0);
        chk("rstmid_owner", 32'(owner), 32'd0);
        chk("rstmid_busy", 32'(BUSY), 32'd0);
        chk("rstmid_addr", 32'(vram_addr_b), 32'd0);
        chk("rstmid_data", 32'(vram_data_b), 32'd0);
        r_left[REQ_PLOT] = 0;
        drive();
        model_reset();
        run_len  = 0;
        prev_rdy = '0;
        @(posedge CLK);
        #1 rst = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
